alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 8-bit combinational ALU: WIDTH-bit datapath, 5-bit opcode,
//  valid/ready handshake on input and output, status flags, accumulator operand mode and an
//  iterative shift-add multiplier. Sits between an operand source (sequencer/regfile) and a result sink.
// PARAMETERS
//  WIDTH  8  operand/result width (>=2)
//  ROT    2  rotate-right amount for ops 14/15, taken modulo WIDTH
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        synchronous, active-high reset
//  in_valid  in   1        operand/opcode presented
//  in_ready  out  1        block can accept; transfer when in_valid & in_ready
//  i1        in   WIDTH    operand A (ignored when acc_en=1)
//  i2        in   WIDTH    operand B
//  sel       in   5        opcode
//  acc_en    in   1        1: operand A = internal accumulator
//  out_valid out  1        result/flags valid
//  out_ready in   1        sink accepts; result consumed when out_valid & out_ready
//  res       out  WIDTH    result (MUL: low half)
//  res_hi    out  WIDTH    MUL high half; 0 for all other ops
//  flag_c/z/n/v out 1 each carry/borrow, zero, negative, signed overflow
// BEHAVIOUR
//  Reset: state IDLE, in_ready=0 during rst, 1 the cycle after; out_valid, res, res_hi, flags, acc = 0.
//  Opcodes 0-15 as legacy map: 0 ADD,1 SUB,2 OR,3 AND,4 XOR,5 NOT A,6 NOT B,7 NOR,8 NAND,9 XNOR,
//   10 SHR A,11 SHR B,12 SHL A,13 SHL B (by 1),14 ROR A by ROT,15 ROR B by ROT; 16 MUL (unsigned);
//   17-31 reserved: res=0, res_hi=0, Z=1, other flags 0.
//  Flags: C = ADD carry-out; SUB borrow (1 iff A<B unsigned); shifts: bit shifted out; else 0.
//   Z = (res==0) and, for MUL, (res_hi==0). N = res[WIDTH-1] (MUL: res_hi[WIDTH-1]).
//   V = signed overflow for ADD/SUB only, else 0. ADD/SUB results wrap modulo 2^WIDTH.
//  FSM: IDLE -> (accept, ops!=16) HOLD; IDLE -> (accept MUL) BUSY; BUSY counts WIDTH cycles, one
//   shift-add step per cycle, -> HOLD; HOLD -> IDLE when out_ready and no new accept.
//  Latency (accept edge to out_valid=1): single-cycle ops 1 clk; MUL WIDTH+1 clks.
//  in_ready = 1 in IDLE; 1 in HOLD iff out_ready; 0 in BUSY.
//  HOLD with out_ready & in_valid: result consumed and new op accepted same edge; single-cycle op
//   keeps out_valid=1 with new result next cycle (full throughput); MUL drops out_valid to 0.
//  Backpressure: while out_valid & !out_ready, res/res_hi/flags held stable, no accept.
//  Operands/opcode/acc_en captured at accept; later input changes have no effect on that op.
//  Accumulator loads res on the edge out_valid is asserted for a new result; acc_en on a back-to-back
//   op therefore sees the immediately preceding result. MUL uses acc as multiplicand when acc_en=1.
//  rst in any state (incl. mid-MUL or HOLD) aborts: no out_valid for the aborted op, all regs reset.
// TESTING (WIDTH=8, ROT=2)
//  ADD 200+100, out_ready=1 -> 1 clk later out_valid=1, res=44, C=1, V=0, Z=0, N=0.
//  SUB 5-7 -> res=254, C=1, N=1, V=0; ADD 100+100 -> res=200, V=1, N=1, C=0.
//  MUL 200*200 -> in_ready=0 for 8 clks, out_valid on clk 9, res=0x40, res_hi=0x9C; ROR A 0xB1 -> 0x6C.
//  acc_en chain: ADD 3+4 then back-to-back acc_en ADD i2=10 -> results 7 then 17, out_valid held 1.
//  out_ready=0 for 3 clks after result -> res/flags stable, in_ready=0; then out_ready=1 -> consumed.
//  rst asserted mid-MUL (clk 4) -> next clk out_valid=0, res=0, acc=0; sel=20 -> res=0, Z=1.

Source files
------------

// File: rtl/alu_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_if
// Handshake bundle between an operand source / result sink and alu_pipe.
//   master : operand source + result sink (drives in_valid, i1, i2, sel,
//            acc_en, out_ready; observes in_ready and the result side)
//   slave  : the ALU itself (drives in_ready, out_valid, res, res_hi, flags)
// Signals
//   in_valid/in_ready   input handshake, transfer when both are 1
//   i1, i2              operands A and B (WIDTH bits)
//   sel                 5-bit opcode
//   acc_en              1: operand A comes from the internal accumulator
//   out_valid/out_ready output handshake, result consumed when both are 1
//   res, res_hi         result (MUL: low / high half), res_hi 0 otherwise
//   flag_c/z/n/v        carry/borrow, zero, negative, signed overflow
// ---------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [4:0]       sel;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output in_valid, i1, i2, sel, acc_en, out_ready,
        input  in_ready, out_valid, res, res_hi, flag_c, flag_z, flag_n, flag_v
    );

    modport slave (
        input  in_valid, i1, i2, sel, acc_en, out_ready,
        output in_ready, out_valid, res, res_hi, flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides, status
// flags, an accumulator operand mode and an iterative shift-add multiplier.
// Single-cycle ops produce a result on the accept edge; MUL (opcode 16)
// runs WIDTH shift-add steps in BUSY before the result is presented.
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any op in flight
//   bus   alu_pipe_if.slave: operand/opcode input, result/flags output
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int ROT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe_if.slave    bus
);

    localparam int ROT_AMT = ROT % WIDTH;
    localparam int CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             is_mul;
    logic             in_ready;

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             out_valid;
    logic [WIDTH-1:0] acc;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last_step;

    // Single-cycle ALU result
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // in_ready is forced low while rst is high so nothing is accepted on the
    // reset edge itself.
    assign in_ready = !rst && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;
    assign is_mul   = (bus.sel == 5'd16);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.res       = res;
    assign bus.res_hi    = res_hi;
    assign bus.flag_c    = flag_c;
    assign bus.flag_z    = flag_z;
    assign bus.flag_n    = flag_n;
    assign bus.flag_v    = flag_v;

    // One shift-add step: {mul_hi, mul_lo} holds the partial product with the
    // unconsumed multiplier bits in the low half; after WIDTH steps it holds
    // the full 2*WIDTH product.
    assign step_sum  = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
    assign step_hi   = step_sum[WIDTH:1];
    assign step_lo   = {step_sum[0], mul_lo[WIDTH-1:1]};
    assign last_step = (cnt == CW'(WIDTH - 1));

    // Combinational single-cycle ALU, evaluated on the live inputs so the
    // result can be registered on the accept edge.
    always_comb begin
        op_a     = bus.acc_en ? acc : bus.i1;
        op_b     = bus.i2;
        add_full = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.sel)
            5'd0: begin
                add_full = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = add_full[WIDTH-1:0];
                alu_c    = add_full[WIDTH];
                alu_v    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            5'd1: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            5'd2:  alu_res = op_a | op_b;
            5'd3:  alu_res = op_a & op_b;
            5'd4:  alu_res = op_a ^ op_b;
            5'd5:  alu_res = ~op_a;
            5'd6:  alu_res = ~op_b;
            5'd7:  alu_res = ~(op_a | op_b);
            5'd8:  alu_res = ~(op_a & op_b);
            5'd9:  alu_res = ~(op_a ^ op_b);
            5'd10: begin
                alu_res = op_a >> 1;
                alu_c   = op_a[0];
            end
            5'd11: begin
                alu_res = op_b >> 1;
                alu_c   = op_b[0];
            end
            5'd12: begin
                alu_res = op_a << 1;
                alu_c   = op_a[WIDTH-1];
            end
            5'd13: begin
                alu_res = op_b << 1;
                alu_c   = op_b[WIDTH-1];
            end
            // A rotate loses no bits, so carry stays 0. With ROT_AMT==0 the
            // left shift moves everything out and the operand passes through.
            5'd14: alu_res = (op_a >> ROT_AMT) | (op_a << (WIDTH - ROT_AMT));
            5'd15: alu_res = (op_b >> ROT_AMT) | (op_b << (WIDTH - ROT_AMT));
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A new accept in HOLD takes priority over returning
    // to IDLE, which gives full throughput for back-to-back single-cycle ops.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : HOLD;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : HOLD;
                end else if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: result/flag registers, accumulator and multiplier. The
    // accumulator is loaded together with every new result so a following
    // acc_en op sees it immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            res       <= '0;
            res_hi    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mul_hi    <= '0;
            mul_lo    <= '0;
            cnt       <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand     <= op_a;
                mul_lo    <= op_b;
                mul_hi    <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                res       <= alu_res;
                res_hi    <= '0;
                flag_c    <= alu_c;
                flag_z    <= (alu_res == '0);
                flag_n    <= alu_res[WIDTH-1];
                flag_v    <= alu_v;
                out_valid <= 1'b1;
                acc       <= alu_res;
            end
        end else if (state == BUSY) begin
            mul_hi <= step_hi;
            mul_lo <= step_lo;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
                res       <= step_lo;
                res_hi    <= step_hi;
                flag_c    <= 1'b0;
                flag_z    <= (step_lo == '0) && (step_hi == '0);
                flag_n    <= step_hi[WIDTH-1];
                flag_v    <= 1'b0;
                out_valid <= 1'b1;
                acc       <= step_lo;
            end
        end else if ((state == HOLD) && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe (WIDTH=8, ROT=2). Directed scenarios
// followed by randomized traffic, all checked against an arithmetic
// reference model with a queue of expected results.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(
        .WIDTH(W),
        .ROT  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int res;
        int hi;
        bit c;
        bit z;
        bit n;
        bit v;
    } exp_t;

    int   checks    = 0;
    int   errors    = 0;
    exp_t exp_q[$];
    int   model_acc = 0;
    int   pending   = 0;

    // Counts a comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: results from plain integer arithmetic on 0..255.
    function automatic exp_t refOp(input int s, input int a, input int b);
        exp_t e;
        int   t;
        int   sa;
        int   sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        e.res = 0;
        e.hi  = 0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        case (s)
            0: begin
                t     = a + b;
                e.res = t % 256;
                e.c   = (t > 255);
                e.v   = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            1: begin
                e.res = (a - b + 256) % 256;
                e.c   = (a < b);
                e.v   = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            2:  e.res = a | b;
            3:  e.res = a & b;
            4:  e.res = a ^ b;
            5:  e.res = 255 - a;
            6:  e.res = 255 - b;
            7:  e.res = 255 - (a | b);
            8:  e.res = 255 - (a & b);
            9:  e.res = 255 - (a ^ b);
            10: begin e.res = a / 2;         e.c = (a % 2) == 1; end
            11: begin e.res = b / 2;         e.c = (b % 2) == 1; end
            12: begin e.res = (a * 2) % 256; e.c = (a >= 128);   end
            13: begin e.res = (b * 2) % 256; e.c = (b >= 128);   end
            14: e.res = (a % 4) * 64 + a / 4;
            15: e.res = (b % 4) * 64 + b / 4;
            16: begin
                t     = a * b;
                e.res = t % 256;
                e.hi  = t / 256;
            end
            default: e.res = 0;
        endcase
        e.z = (e.res == 0) && (e.hi == 0);
        e.n = (s == 16) ? (e.hi >= 128) : (e.res >= 128);
        return e;
    endfunction

    // Drives one cycle of inputs at the falling edge, checks handshake and
    // consumed results against the model, then advances one clock.
    task automatic applyStimulus(input logic r, input logic v, input int a, input int b,
                                 input int s, input logic ae, input logic ordy);
        bit   exp_busy;
        bit   exp_ov;
        bit   exp_ir;
        exp_t e;
        rst           = r;
        bus.in_valid  = v;
        bus.i1        = W'(a);
        bus.i2        = W'(b);
        bus.sel       = 5'(s);
        bus.acc_en    = ae;
        bus.out_ready = ordy;
        #1;
        exp_busy = (pending > 0);
        exp_ov   = !exp_busy && (exp_q.size() > 0);
        exp_ir   = !r && !exp_busy && (!exp_ov || ordy);
        checkOutput("in_ready", bus.in_ready, exp_ir);
        if (!r) begin
            checkOutput("out_valid", bus.out_valid, exp_ov);
            if (exp_ov && ordy) begin
                e = exp_q.pop_front();
                checkOutput("res", bus.res, e.res);
                checkOutput("res_hi", bus.res_hi, e.hi);
                checkOutput("flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, {e.c, e.z, e.n, e.v});
            end
            if (v && exp_ir) begin
                e = refOp(s, ae ? model_acc : (a % 256), b % 256);
                exp_q.push_back(e);
                model_acc = e.res;
                if (s == 16) pending = W;
            end else if (pending > 0) begin
                pending--;
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            pending   = 0;
            model_acc = 0;
        end
        @(negedge clk);
    endtask

    // Keeps the run bounded if the DUT stalls the handshake.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cycles;
        int lat;
        int s;
        @(negedge clk);

        // Reset and accumulator cleared
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_res", bus.res, 0);
        checkOutput("rst_res_hi", bus.res_hi, 0);
        checkOutput("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b0000);
        applyStimulus(0, 1, 99, 5, 0, 1, 1);
        checkOutput("acc_after_rst", bus.res, 5);

        // Flag scenarios
        applyStimulus(0, 1, 200, 100, 0, 0, 1);
        checkOutput("add_valid", bus.out_valid, 1);
        checkOutput("add_res", bus.res, 44);
        checkOutput("add_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b1000);
        applyStimulus(0, 1, 5, 7, 1, 0, 1);
        checkOutput("sub_res", bus.res, 254);
        checkOutput("sub_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b1010);
        applyStimulus(0, 1, 100, 100, 0, 0, 1);
        checkOutput("ovf_res", bus.res, 200);
        checkOutput("ovf_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b0011);
        applyStimulus(0, 1, 'hB1, 0, 14, 0, 1);
        checkOutput("ror_res", bus.res, 'h6C);

        // MUL latency and busy window
        applyStimulus(0, 1, 200, 200, 16, 0, 1);
        busy_cycles = 0;
        lat         = 1;
        while (!bus.out_valid && lat < 30) begin
            if (!bus.in_ready) busy_cycles++;
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            lat++;
        end
        checkOutput("mul_busy", busy_cycles, 8);
        checkOutput("mul_latency", lat, 9);
        checkOutput("mul_res", bus.res, 'h40);
        checkOutput("mul_res_hi", bus.res_hi, 'h9C);

        // Back-to-back accumulator chain
        applyStimulus(0, 1, 3, 4, 0, 0, 1);
        checkOutput("chain_first", bus.res, 7);
        applyStimulus(0, 1, 0, 10, 0, 1, 1);
        checkOutput("chain_second", bus.res, 17);
        checkOutput("chain_valid", bus.out_valid, 1);

        // Backpressure: result held, new op refused
        applyStimulus(0, 1, 9, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 50, 50, 0, 0, 0);
            checkOutput("bp_hold_res", bus.res, 10);
            checkOutput("bp_hold_valid", bus.out_valid, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("bp_consumed", bus.out_valid, 0);

        // Reset in the middle of a MUL
        applyStimulus(0, 1, 200, 200, 16, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("abort_valid", bus.out_valid, 0);
        checkOutput("abort_res", bus.res, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 77, 3, 0, 1, 1);
        checkOutput("abort_acc", bus.res, 3);

        // Reserved opcode
        applyStimulus(0, 1, 123, 45, 20, 0, 1);
        checkOutput("rsv_res", bus.res, 0);
        checkOutput("rsv_res_hi", bus.res_hi, 0);
        checkOutput("rsv_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b0100);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            applyStimulus(0, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), s, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 9) < 7));
        end
        for (int k = 0; k < 30 && (exp_q.size() > 0); k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
        end
        checkOutput("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
